// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS multi-cycle control path.
// Opcodes, functs, ALU operations, sequencer states and decode classes.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  localparam logic [3:0] ALUOP_ADD = 4'd0;
  localparam logic [3:0] ALUOP_AND = 4'd1;
  localparam logic [3:0] ALUOP_OR  = 4'd2;
  localparam logic [3:0] ALUOP_XOR = 4'd3;
  localparam logic [3:0] ALUOP_SUB = 4'd4;
  localparam logic [3:0] ALUOP_SLT = 4'd5;

  typedef enum logic [7:0] {
    S_FETCH  = 8'h01,
    S_FWAIT  = 8'h02,
    S_DECODE = 8'h04,
    S_EXEC   = 8'h08,
    S_MEM    = 8'h10,
    S_MWAIT  = 8'h20,
    S_WB     = 8'h40,
    S_HALT   = 8'h80
  } state_t;

  typedef enum logic [3:0] {
    CL_R, CL_IMM, CL_LW, CL_SW, CL_SH,
    CL_SB, CL_BEQ, CL_BNE, CL_J, CL_ILL
  } cls_t;

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational instruction classifier.
// Maps opcode/funct to class, ALU operation and operand selects.
module mips_ctrl_decode
  import mips_pkg::*;
#(
  parameter int ALUOP_W = 4
) (
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  output cls_t               cls,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               imm_zext,
  output logic               reg_dst,
  output logic               illegal
);

  logic [3:0] aop;

  // Classify the instruction word held in IR
  always_comb begin
    cls      = CL_ILL;
    aop      = ALUOP_ADD;
    imm_zext = 1'b0;
    reg_dst  = 1'b0;
    unique case (opcode)
      OP_RTYPE: begin
        reg_dst = 1'b1;
        cls     = CL_R;
        unique case (funct)
          FN_ADD, FN_ADDU: aop = ALUOP_ADD;
          FN_SUB, FN_SUBU: aop = ALUOP_SUB;
          FN_AND:          aop = ALUOP_AND;
          FN_OR:           aop = ALUOP_OR;
          FN_XOR:          aop = ALUOP_XOR;
          FN_SLT:          aop = ALUOP_SLT;
          default:         cls = CL_ILL;
        endcase
      end
      OP_ADDI, OP_ADDIU: cls = CL_IMM;
      OP_SLTI: begin
        cls = CL_IMM;
        aop = ALUOP_SLT;
      end
      OP_ANDI: begin
        cls      = CL_IMM;
        aop      = ALUOP_AND;
        imm_zext = 1'b1;
      end
      OP_ORI: begin
        cls      = CL_IMM;
        aop      = ALUOP_OR;
        imm_zext = 1'b1;
      end
      OP_XORI: begin
        cls      = CL_IMM;
        aop      = ALUOP_XOR;
        imm_zext = 1'b1;
      end
      OP_LW: cls = CL_LW;
      OP_SW: cls = CL_SW;
      OP_SH: cls = CL_SH;
      OP_SB: cls = CL_SB;
      OP_BEQ: begin
        cls = CL_BEQ;
        aop = ALUOP_SUB;
      end
      OP_BNE: begin
        cls = CL_BNE;
        aop = ALUOP_SUB;
      end
      OP_J:    cls = CL_J;
      default: cls = CL_ILL;
    endcase
  end

  assign alu_op  = ALUOP_W'(aop);
  assign illegal = (cls == CL_ILL);

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle control sequencer for the MIPS datapath.
// One-hot state register plus per-state output decode.
module mips_mc_ctrl
  import mips_pkg::*;
#(
  parameter int ALUOP_W  = 4,
  parameter bit TRAP_ILL = 1'b1
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               alu_zero,
  input  logic [1:0]         addr_lo,
  output logic               pc_we,
  output logic [1:0]         pc_src,
  output logic               ir_we,
  output logic               reg_we,
  output logic               reg_dst,
  output logic               alu_src,
  output logic               imm_zext,
  output logic               mem_to_reg,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [3:0]         wr,
  output logic               halted
);

  state_t             state;
  logic [1:0]         addr_q;
  cls_t               cls;
  logic [ALUOP_W-1:0] d_aop;
  logic               d_zext;
  logic               d_rdst;
  logic               d_ill;
  logic               mis;

  mips_ctrl_decode #(.ALUOP_W(ALUOP_W)) u_dec (
    .opcode   (opcode),
    .funct    (funct),
    .cls      (cls),
    .alu_op   (d_aop),
    .imm_zext (d_zext),
    .reg_dst  (d_rdst),
    .illegal  (d_ill)
  );

  // ALUOut byte offset is only valid in EXEC; hold it for MEM
  assign mis = ((cls == CL_SW) && (addr_q != 2'd0))
            || ((cls == CL_SH) && addr_q[0]);

  // Sequencer state and captured byte offset
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state  <= S_FETCH;
      addr_q <= 2'd0;
    end else begin
      unique case (state)
        S_FETCH:  state <= S_FWAIT;
        S_FWAIT:  state <= S_DECODE;
        S_DECODE: begin
          if (!d_ill)        state <= S_EXEC;
          else if (TRAP_ILL) state <= S_HALT;
          else               state <= S_FETCH;
        end
        S_EXEC: begin
          addr_q <= addr_lo;
          if (cls inside {CL_R, CL_IMM})
            state <= S_WB;
          else if (cls inside {CL_LW, CL_SW, CL_SH, CL_SB})
            state <= S_MEM;
          else
            state <= S_FETCH;
        end
        S_MEM: begin
          if (cls == CL_LW) state <= S_MWAIT;
          else if (mis)     state <= S_HALT;
          else              state <= S_FETCH;
        end
        S_MWAIT:  state <= S_WB;
        S_WB:     state <= S_FETCH;
        S_HALT:   state <= S_HALT;
        default:  state <= S_FETCH;
      endcase
    end
  end

  // Per-state datapath controls; strobes masked while reset is held
  always_comb begin
    pc_we      = 1'b0;
    pc_src     = 2'd0;
    ir_we      = 1'b0;
    reg_we     = 1'b0;
    reg_dst    = 1'b0;
    alu_src    = 1'b0;
    imm_zext   = 1'b0;
    mem_to_reg = 1'b0;
    alu_op     = ALUOP_W'(ALUOP_ADD);
    wr         = 4'd0;
    halted     = 1'b0;
    unique case (state)
      S_FWAIT: begin
        ir_we = 1'b1;
        pc_we = 1'b1;
      end
      S_EXEC: begin
        alu_op   = d_aop;
        imm_zext = d_zext;
        alu_src  = cls inside {CL_IMM, CL_LW, CL_SW, CL_SH, CL_SB};
        if (cls inside {CL_BEQ, CL_BNE}) begin
          pc_we  = alu_zero ^ (cls == CL_BNE);
          pc_src = 2'd1;
        end else if (cls == CL_J) begin
          pc_we  = 1'b1;
          pc_src = 2'd2;
        end
      end
      S_MEM: begin
        if (!mis) begin
          unique case (cls)
            CL_SW:   wr = 4'b1111;
            CL_SH:   wr = addr_q[1] ? 4'b1100 : 4'b0011;
            CL_SB:   wr = 4'b0001 << addr_q;
            default: wr = 4'b0000;
          endcase
        end
      end
      S_WB: begin
        reg_we     = 1'b1;
        reg_dst    = d_rdst;
        mem_to_reg = (cls == CL_LW);
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
    if (!nrst) begin
      pc_we  = 1'b0;
      ir_we  = 1'b0;
      reg_we = 1'b0;
      wr     = 4'd0;
    end
  end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Self-checking bench for mips_mc_ctrl.
// Directed table, reset corners and random instruction stream.
module tb_mips_mc_ctrl;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       alu_zero = 1'b0;
  logic [1:0] addr_lo = '0;
  logic       pc_we, ir_we, reg_we, reg_dst;
  logic       alu_src, imm_zext, mem_to_reg, halted;
  logic [1:0] pc_src;
  logic [3:0] alu_op;
  logic [3:0] wr;

  mips_mc_ctrl #(.ALUOP_W(4), .TRAP_ILL(1'b1)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .opcode     (opcode),
    .funct      (funct),
    .alu_zero   (alu_zero),
    .addr_lo    (addr_lo),
    .pc_we      (pc_we),
    .pc_src     (pc_src),
    .ir_we      (ir_we),
    .reg_we     (reg_we),
    .reg_dst    (reg_dst),
    .alu_src    (alu_src),
    .imm_zext   (imm_zext),
    .mem_to_reg (mem_to_reg),
    .alu_op     (alu_op),
    .wr         (wr),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_we;
    logic [1:0] pc_src;
    logic       ir_we;
    logic       reg_we;
    logic       reg_dst;
    logic       alu_src;
    logic       imm_zext;
    logic       mem_to_reg;
    logic [3:0] alu_op;
    logic [3:0] wr;
    logic       halted;
  } out_t;

  typedef enum {
    K_R, K_I, K_LW, K_SW, K_SH, K_SB,
    K_BEQ, K_BNE, K_J, K_ILL
  } kind_t;

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] fn;
    kind_t      kind;
    logic [3:0] aop;
    logic       zext;
  } ins_t;

  typedef struct {
    string      nm;
    logic       z;
    logic [1:0] a;
    int         cpi;
    logic [3:0] wr;
    logic       h;
  } vec_t;

  ins_t it[$];
  vec_t vt[$];
  out_t q[$];
  logic mdl_halt;
  int   errors = 0;
  int   checks = 0;

  task automatic add_ins(input string n, input logic [5:0] op,
                         input logic [5:0] fn, input kind_t k,
                         input logic [3:0] aop, input logic zx);
    ins_t e;
    e.name = n; e.op = op; e.fn = fn;
    e.kind = k; e.aop = aop; e.zext = zx;
    it.push_back(e);
  endtask

  task automatic add_vec(input string n, input logic z,
                         input logic [1:0] a, input int cpi,
                         input logic [3:0] w, input logic h);
    vec_t v;
    v.nm = n; v.z = z; v.a = a;
    v.cpi = cpi; v.wr = w; v.h = h;
    vt.push_back(v);
  endtask

  function automatic int find(input string n);
    for (int i = 0; i < it.size(); i++)
      if (it[i].name == n) return i;
    return 0;
  endfunction

  function automatic out_t got();
    out_t o;
    o.pc_we = pc_we; o.pc_src = pc_src; o.ir_we = ir_we;
    o.reg_we = reg_we; o.reg_dst = reg_dst; o.alu_src = alu_src;
    o.imm_zext = imm_zext; o.mem_to_reg = mem_to_reg;
    o.alu_op = alu_op; o.wr = wr; o.halted = halted;
    return o;
  endfunction

  task automatic chk(input string n, input out_t g, input out_t e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s got=%h want=%h", n, g, e);
    end
  endtask

  task automatic chk_i(input string n, input int g, input int e);
    checks++;
    if (g != e) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", n, g, e);
    end
  endtask

  // Expected cycles from DECODE through the next FWAIT (or 3 HALT cycles)
  task automatic build(input ins_t in, input logic z, input logic [1:0] a);
    out_t o;
    bit   h;
    q.delete();
    h = 0;
    o = '0; q.push_back(o);
    if (in.kind == K_ILL) h = 1;
    else begin
      o = '0;
      o.alu_op = in.aop;
      o.imm_zext = in.zext;
      o.alu_src = in.kind inside {K_I, K_LW, K_SW, K_SH, K_SB};
      if (in.kind == K_BEQ) begin o.pc_we = z; o.pc_src = 1; end
      if (in.kind == K_BNE) begin o.pc_we = !z; o.pc_src = 1; end
      if (in.kind == K_J) begin o.pc_we = 1; o.pc_src = 2; end
      q.push_back(o);
      o = '0;
      case (in.kind)
        K_LW: begin q.push_back(o); q.push_back(o); end
        K_SW: begin
          if (a == 0) o.wr = 4'hf; else h = 1;
          q.push_back(o);
        end
        K_SH: begin
          if (a % 2 == 1) h = 1;
          else o.wr = (a >= 2) ? 4'hc : 4'h3;
          q.push_back(o);
        end
        K_SB: begin o.wr = 4'(1 << a); q.push_back(o); end
        default: ;
      endcase
      if (in.kind inside {K_R, K_I, K_LW}) begin
        o = '0;
        o.reg_we = 1;
        o.reg_dst = (in.kind == K_R);
        o.mem_to_reg = (in.kind == K_LW);
        q.push_back(o);
      end
    end
    if (h) begin
      o = '0; o.halted = 1;
      repeat (3) q.push_back(o);
    end else begin
      o = '0; q.push_back(o);
      o.ir_we = 1; o.pc_we = 1; q.push_back(o);
    end
    mdl_halt = h;
  endtask

  // Starts and ends 1ns after the edge that enters DECODE
  task automatic run(input ins_t in, input logic z, input logic [1:0] a,
                     output int cpi, output logic [3:0] ws,
                     output logic hl);
    out_t g;
    build(in, z, a);
    cpi = 0; ws = 0; hl = 0;
    opcode = in.op;
    funct = in.fn;
    for (int k = 0; k < q.size(); k++) begin
      alu_zero = (k == 1) ? z : 1'($urandom);
      addr_lo = (k == 1) ? a : 2'($urandom);
      @(negedge clk);
      g = got();
      chk($sformatf("%s_c%0d", in.name, k), g, q[k]);
      ws |= g.wr;
      hl = g.halted;
      if (k > 0 && g.ir_we && cpi == 0) cpi = k + 1;
      @(posedge clk); #1;
    end
  endtask

  // Check FETCH and FWAIT after the state register returns to FETCH
  task automatic prime(input string n);
    out_t e;
    @(negedge clk);
    e = '0;
    chk({n, "_fetch"}, got(), e);
    @(posedge clk); #1;
    @(negedge clk);
    e.ir_we = 1; e.pc_we = 1;
    chk({n, "_fwait"}, got(), e);
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input string n);
    nrst = 1'b0;
    @(posedge clk); #1;
    nrst = 1'b1;
    prime(n);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int         cpi;
    logic [3:0] ws;
    logic       hl;
    int         ix;
    out_t       e;

    add_ins("add",  6'o00, 6'o40, K_R, 4'd0, 0);
    add_ins("addu", 6'o00, 6'o41, K_R, 4'd0, 0);
    add_ins("sub",  6'o00, 6'o42, K_R, 4'd4, 0);
    add_ins("subu", 6'o00, 6'o43, K_R, 4'd4, 0);
    add_ins("and",  6'o00, 6'o44, K_R, 4'd1, 0);
    add_ins("or",   6'o00, 6'o45, K_R, 4'd2, 0);
    add_ins("xor",  6'o00, 6'o46, K_R, 4'd3, 0);
    add_ins("slt",  6'o00, 6'o52, K_R, 4'd5, 0);
    add_ins("addi", 6'o10, 6'o00, K_I, 4'd0, 0);
    add_ins("addiu",6'o11, 6'o17, K_I, 4'd0, 0);
    add_ins("slti", 6'o12, 6'o00, K_I, 4'd5, 0);
    add_ins("andi", 6'o14, 6'o44, K_I, 4'd1, 1);
    add_ins("ori",  6'o15, 6'o00, K_I, 4'd2, 1);
    add_ins("xori", 6'o16, 6'o00, K_I, 4'd3, 1);
    add_ins("lw",   6'o43, 6'o00, K_LW, 4'd0, 0);
    add_ins("sw",   6'o53, 6'o00, K_SW, 4'd0, 0);
    add_ins("sh",   6'o51, 6'o00, K_SH, 4'd0, 0);
    add_ins("sb",   6'o50, 6'o00, K_SB, 4'd0, 0);
    add_ins("beq",  6'o04, 6'o00, K_BEQ, 4'd4, 0);
    add_ins("bne",  6'o05, 6'o00, K_BNE, 4'd4, 0);
    add_ins("j",    6'o02, 6'o00, K_J, 4'd0, 0);
    add_ins("ill",  6'o77, 6'o00, K_ILL, 4'd0, 0);
    add_ins("sll",  6'o00, 6'o00, K_ILL, 4'd0, 0);
    add_ins("lui",  6'o17, 6'o00, K_ILL, 4'd0, 0);

    add_vec("add",  0, 0, 5, 4'h0, 0);
    add_vec("lw",   0, 1, 7, 4'h0, 0);
    add_vec("sb",   0, 2, 5, 4'h4, 0);
    add_vec("sb",   1, 3, 5, 4'h8, 0);
    add_vec("sh",   0, 2, 5, 4'hc, 0);
    add_vec("sh",   0, 0, 5, 4'h3, 0);
    add_vec("sw",   0, 0, 5, 4'hf, 0);
    add_vec("sw",   0, 1, 0, 4'h0, 1);
    add_vec("sh",   0, 3, 0, 4'h0, 1);
    add_vec("beq",  1, 0, 4, 4'h0, 0);
    add_vec("beq",  0, 0, 4, 4'h0, 0);
    add_vec("bne",  1, 0, 4, 4'h0, 0);
    add_vec("j",    0, 0, 4, 4'h0, 0);
    add_vec("andi", 0, 0, 5, 4'h0, 0);
    add_vec("ill",  0, 0, 0, 4'h0, 1);
    add_vec("slt",  0, 0, 5, 4'h0, 0);

    // Reset state while nrst is held
    nrst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    e = '0;
    chk("reset_hold", got(), e);
    @(posedge clk); #1;
    nrst = 1'b1;
    prime("reset");

    foreach (vt[i]) begin
      ix = find(vt[i].nm);
      run(it[ix], vt[i].z, vt[i].a, cpi, ws, hl);
      chk_i({vt[i].nm, "_cpi"}, cpi, vt[i].cpi);
      chk_i({vt[i].nm, "_wr"}, int'(ws), int'(vt[i].wr));
      chk_i({vt[i].nm, "_halt"}, int'(hl), int'(vt[i].h));
      if (vt[i].h) do_reset({vt[i].nm, "_rst"});
    end

    // Reset asserted during the MEM cycle of an aligned sw
    opcode = 6'o53;
    funct = 6'o00;
    @(negedge clk);
    @(posedge clk); #1;
    addr_lo = 2'd0;
    @(posedge clk); #1;
    nrst = 1'b0;
    @(negedge clk);
    e = '0;
    chk("mem_reset_wr", got(), e);
    @(posedge clk); #1;
    nrst = 1'b1;
    prime("mem_reset");

    for (int n = 0; n < 300; n++) begin
      ix = $urandom_range(0, it.size() - 1);
      run(it[ix], 1'($urandom), 2'($urandom), cpi, ws, hl);
      if (mdl_halt) do_reset("rnd_rst");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
